// File: rtl/spi_slave_param.sv
// SPI slave front end for the single-port RAM: receives {cmd, payload} frames, returns read data on MISO.
// Optional odd-parity framing in both directions is built when SPI_PARITY_EN is defined.
module spi_slave_param #(
  parameter int PAY_W      = 8,
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [PAY_W+1:0]  rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int N = PAY_W + 2;
`ifdef SPI_PARITY_EN
  localparam int FRAME_N = N + 1;
  localparam int SEND_N  = DATA_W + 1;
`else
  localparam int FRAME_N = N;
  localparam int SEND_N  = DATA_W;
`endif
  localparam int CNT_MAX = (FRAME_N > SEND_N)
                         ? ((FRAME_N > TX_TIMEOUT) ? FRAME_N : TX_TIMEOUT)
                         : ((SEND_N > TX_TIMEOUT) ? SEND_N : TX_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_TX, SEND, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [FRAME_N-1:0]  sr, sr_next, sr_shift;
  logic [SEND_N-1:0]   tx_sr, tx_sr_next, tx_word;
  logic [N-1:0]        frame, rx_data_next;
  logic [1:0]          cmd;
  logic                miso_next, rx_valid_next, frame_err_next;
  logic                rd_addr_flag, flag_next, frame_ok;

  assign sr_shift = {sr[FRAME_N-2:0], MOSI};
  assign frame    = sr_shift[FRAME_N-1 -: N];
  assign cmd      = frame[N-1:N-2];
  assign busy     = (state != IDLE);

`ifdef SPI_PARITY_EN
  // odd parity: the received word including its parity bit must hold an odd number of ones
  assign frame_ok = ^sr_shift;
  assign tx_word  = {tx_data, ~^tx_data};
`else
  assign frame_ok = 1'b1;
  assign tx_word  = tx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      tx_sr        <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_flag <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      sr           <= sr_next;
      tx_sr        <= tx_sr_next;
      MISO         <= miso_next;
      rx_data      <= rx_data_next;
      rx_valid     <= rx_valid_next;
      frame_err    <= frame_err_next;
      rd_addr_flag <= flag_next;
    end
  end

  // cnt is a down-counter in every state; reaching zero marks the last bit or the timeout edge
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    sr_next        = sr;
    tx_sr_next     = tx_sr;
    miso_next      = MISO;
    rx_data_next   = rx_data;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    flag_next      = rd_addr_flag;
    case (state)
      IDLE: begin
        if (!SS_n) begin
          state_next = RECV;
          cnt_next   = CNT_W'(FRAME_N - 1);
        end
      end
      RECV: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
        end else begin
          sr_next = sr_shift;
          if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
          end else begin
            state_next = DONE;
            if (!frame_ok || (cmd == 2'b11 && !rd_addr_flag)) begin
              frame_err_next = 1'b1;
            end else begin
              rx_data_next  = frame;
              rx_valid_next = 1'b1;
              if (cmd == 2'b10) flag_next = 1'b1;
              if (cmd == 2'b11) begin
                state_next = WAIT_TX;
                cnt_next   = CNT_W'(TX_TIMEOUT - 1);
              end
            end
          end
        end
      end
      WAIT_TX: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          flag_next      = 1'b0;
        end else if (tx_valid) begin
          state_next = SEND;
          miso_next  = tx_word[SEND_N-1];
          tx_sr_next = tx_word << 1;
          cnt_next   = CNT_W'(SEND_N - 1);
        end else if (cnt == '0) begin
          state_next     = DONE;
          frame_err_next = 1'b1;
          flag_next      = 1'b0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SEND: begin
        if (SS_n) begin
          state_next     = IDLE;
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          flag_next      = 1'b0;
        end else if (cnt == '0) begin
          state_next = DONE;
          miso_next  = 1'b0;
          flag_next  = 1'b0;
        end else begin
          miso_next  = tx_sr[SEND_N-1];
          tx_sr_next = tx_sr << 1;
          cnt_next   = cnt - 1'b1;
        end
      end
      DONE: begin
        miso_next = 1'b0;
        if (SS_n) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
